// File: rtl/boot_loader.sv
// Serial-to-memory program loader: decodes a little-endian {start address, word count, words}
// byte stream, writes the words to instruction memory, then presets the PC and releases the core.
module boot_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [31:0] starting_addr,
  output logic        preset,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_ADDR   = 3'd0,
    S_COUNT  = 3'd1,
    S_DATA   = 3'd2,
    S_PRESET = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic [31:0]   ptr;
  logic [CW-1:0] remaining;

  logic        take;
  logic        last_byte;
  logic [31:0] field_word;

  // Handshake: a byte moves on a clk edge only when rx_valid && rx_ready; rx_ready depends
  // only on state and reset, so a source may sample it before the edge it drives into.
  assign rx_ready = !reset && (state == S_ADDR || state == S_COUNT || state == S_DATA);

  assign take       = rx_valid && rx_ready;
  assign last_byte  = take && (byte_cnt == 2'd3);
  // Earlier bytes sit in shift with the oldest at the bottom, giving little-endian order.
  assign field_word = {rx_data, shift};
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_ADDR;
      byte_cnt      <= 2'd0;
      shift         <= 24'd0;
      ptr           <= 32'd0;
      remaining     <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= 32'd0;
      imem_wdata    <= 32'd0;
      starting_addr <= 32'd0;
      preset        <= 1'b0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      preset  <= 1'b0;
      if (take) begin
        shift    <= {rx_data, shift[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
      end
      case (state)
        S_ADDR: begin
          if (last_byte) begin
            byte_cnt <= 2'd0;
            if (field_word[1:0] != 2'b00) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              starting_addr <= field_word;
              state         <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (last_byte) begin
            byte_cnt <= 2'd0;
            if (field_word == 32'd0 || field_word > 32'(MAX_WORDS)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              remaining <= field_word[CW-1:0];
              ptr       <= starting_addr;
              state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_byte) begin
            byte_cnt   <= 2'd0;
            imem_we    <= 1'b1;
            imem_wdata <= field_word;
            imem_addr  <= ptr;
            ptr        <= ptr + 32'd4;
            remaining  <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state <= S_PRESET;
            end
          end
        end
        S_PRESET: begin
          preset <= 1'b1;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          // The PC samples starting_addr during the preset cycle, so the core may run right after.
          cpu_hold <= 1'b0;
        end
        S_ERR: begin
          err <= 1'b1;
        end
        default: begin
          state <= S_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: expected writes come from the stream's header rules and are
// queued at issue time; a negedge monitor pops and compares each memory write and the preset pulse.
module tb_boot_loader;

  localparam int MAX_WORDS = 1024;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] starting_addr;
  logic        preset;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  boot_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .starting_addr(starting_addr),
    .preset(preset),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] words[$];
  logic [31:0] exp_start;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int write_cnt = 0;
  int preset_cnt = 0;
  int last_we_cyc = 0;
  logic prev_preset = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (!reset) begin
      if (imem_we) begin
        write_cnt++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h/%h required=none", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("imem_write", {imem_addr, imem_wdata}, e);
        end
      end
      if (preset) begin
        preset_cnt++;
        chk("preset_latency", 64'(cyc - last_we_cyc), 64'd1);
        chk("preset_start_addr", {32'd0, starting_addr}, {32'd0, exp_start});
        chk("preset_hold_done", {62'd0, cpu_hold, done}, 64'd3);
      end
      if (prev_preset) chk("hold_release", {62'd0, preset, cpu_hold}, 64'd0);
    end
    prev_preset = reset ? 1'b0 : preset;
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = $urandom_range(max_gap, 0);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept actual=timeout required=rx_ready");
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], max_gap);
  endtask

  task automatic check_reset_values();
    chk("reset_we_preset_done_err", {60'd0, imem_we, preset, done, err}, 64'd0);
    chk("reset_hold_ready", {62'd0, cpu_hold, rx_ready}, 64'd2);
    chk("reset_addr_wdata", {imem_addr, imem_wdata}, 64'd0);
    chk("reset_start_addr", {32'd0, starting_addr}, 64'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_load(input logic [31:0] a, input logic [31:0] n, input int gap);
    logic bad_a;
    logic bad_n;
    logic ok;
    int t;
    do_reset();
    write_cnt  = 0;
    preset_cnt = 0;
    exp_start  = a;
    bad_a = (a[1:0] != 2'b00);
    bad_n = (n == 32'd0) || (n > 32'(MAX_WORDS));
    ok    = !bad_a && !bad_n;
    if (ok) begin
      while (words.size() < int'(n)) words.push_back($urandom);
      for (int i = 0; i < int'(n); i++) exp_q.push_back({a + 32'(4 * i), words[i]});
    end
    send_word(a, gap);
    if (bad_a) begin
      chk("err_after_addr", {60'd0, err, rx_ready, cpu_hold, done}, 64'ha);
    end else begin
      send_word(n, gap);
      if (bad_n) begin
        chk("err_after_count", {60'd0, err, rx_ready, cpu_hold, done}, 64'ha);
      end else begin
        for (int i = 0; i < int'(n); i++) send_word(words[i], gap);
        rx_valid = 1'b0;
        t = 0;
        while (!done && t < 10) begin
          @(negedge clk);
          t++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
      end
    end
    // Input after the loader has finished or failed must be ignored.
    rx_valid = 1'b1;
    repeat (6) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("write_count", 64'(write_cnt), ok ? 64'(n) : 64'd0);
    chk("preset_count", 64'(preset_cnt), ok ? 64'd1 : 64'd0);
    chk("final_done_err_hold_ready", {60'd0, done, err, cpu_hold, rx_ready}, ok ? 64'h8 : 64'h6);
    chk("final_start_addr", {32'd0, starting_addr}, bad_a ? 64'd0 : {32'd0, a});
    exp_q.delete();
    words.delete();
  endtask

  // Stimulus
  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    @(negedge clk);

    words = '{32'h00500093, 32'h00A00113};
    run_load(32'h0000_0100, 32'd2, 0);
    words = '{32'h00500093, 32'h00A00113};
    run_load(32'h0000_0100, 32'd2, 5);

    run_load(32'h0000_0102, 32'd2, 0);
    run_load(32'h0000_0000, 32'd0, 0);
    run_load(32'h0000_0000, 32'(MAX_WORDS + 1), 0);
    run_load(32'h0000_0000, 32'(MAX_WORDS), 0);

    run_load(32'hFFFF_FFFC, 32'd2, 2);

    // Reset in the middle of the data phase: one word written, the next half-received.
    do_reset();
    exp_start = 32'h200;
    words = '{32'h1122_3344};
    exp_q.push_back({32'h200, 32'h1122_3344});
    send_word(32'h200, 0);
    send_word(32'd3, 0);
    send_word(words[0], 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    chk("mid_reset_queue", 64'(exp_q.size()), 64'd0);
    words = '{32'hDEAD_BEEF};
    run_load(32'h0000_0400, 32'd1, 0);

    for (int r = 0; r < 4; r++) begin
      run_load({30'($urandom), 2'b00}, 32'($urandom_range(8, 1)), $urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
